// File: rtl/px_paint_pkg.sv
// Shared types and helpers for the cursor painter: FSM states, direction priority, sizing and addressing.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package px_paint_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // Resolved cursor move for one tick.
  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_RIGHT = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_UP    = 3'd4
  } dir_e;

  // Bit positions inside a 4-bit direction request vector.
  localparam int unsigned DIR_BIT_RIGHT = 0;
  localparam int unsigned DIR_BIT_LEFT  = 1;
  localparam int unsigned DIR_BIT_DOWN  = 2;
  localparam int unsigned DIR_BIT_UP    = 3;

  // Fixed priority among simultaneous requests: right, left, down, up.
  function automatic dir_e px_pick_dir(input logic [3:0] req);
    if (req[DIR_BIT_RIGHT]) return DIR_RIGHT;
    if (req[DIR_BIT_LEFT])  return DIR_LEFT;
    if (req[DIR_BIT_DOWN])  return DIR_DOWN;
    if (req[DIR_BIT_UP])    return DIR_UP;
    return DIR_NONE;
  endfunction

  // Ceiling log2, never less than 1 so that vectors sized with it stay legal.
  function automatic int unsigned px_clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'(1) << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

  // Row-major framebuffer address.
  function automatic int unsigned px_lin_addr(input int unsigned x,
                                              input int unsigned y,
                                              input int unsigned cols);
    return y * cols + x;
  endfunction

endpackage

// File: rtl/px_tick_gen.sv
// Free-running divider producing a one-clk tick every TICK_DIV clocks.
// Latency: first tick TICK_DIV clocks after reset release, then periodic.
// Backpressure: none; the tick is a pure timebase.
// Ports: clk_i clock, rst_ni async active-low reset, tick_o one-clk pulse.
module px_tick_gen
  import px_paint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10714286
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned   CW   = px_clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/px_cursor_painter.sv
// Cursor-driven painter for the VGA framebuffer: moves a 2-D cursor, paints one pixel, or sweeps a clear.
// Latency: cursor move and paint write 1 clk after the tick; clear sweep takes COLS*ROWS clks.
// Backpressure: none; buttons are ignored while busy (history still tracked so no stale edges fire).
// Ports: clk, rst (async active-low); btn_right/left/up/down, btn_paint, clr, switch[DW] inputs;
//        mem_px_addr[AW], mem_px_data[DW], px_wr framebuffer write port; cur_x, cur_y cursor; busy sweep flag.
// Build option: define PX_AUTO_REPEAT_EN to auto-repeat a held direction after REPEAT_TICKS ticks.
module px_cursor_painter
  import px_paint_pkg::*;
#(
  parameter int unsigned    AW           = 8,
  parameter int unsigned    DW           = 3,
  parameter int unsigned    COLS         = 16,
  parameter int unsigned    ROWS         = 12,
  parameter int unsigned    TICK_DIV     = 10714286,
  parameter logic [DW-1:0]  CLR_COLOR    = DW'(3'b111),
  parameter int unsigned    REPEAT_TICKS = 4,
  localparam int unsigned   XW           = px_clog2(COLS),
  localparam int unsigned   YW           = px_clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_right,
  input  logic          btn_left,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_paint,
  input  logic          clr,
  input  logic [DW-1:0] switch,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          busy
);

  localparam int unsigned   NPIX      = COLS * ROWS;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [XW-1:0] X_MAX     = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(ROWS - 1);

  // Parameter sanity checks at elaboration.
  if ((64'(1) << AW) < 64'(NPIX)) begin : g_aw_check
    $error("px_cursor_painter: 2**AW is smaller than COLS*ROWS");
  end
  if (REPEAT_TICKS == 0) begin : g_rpt_check
    $error("px_cursor_painter: REPEAT_TICKS must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Timebase
  // ---------------------------------------------------------------------------
  logic tick;

  px_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i  (clk),
    .rst_ni (rst),
    .tick_o (tick)
  );

  // ---------------------------------------------------------------------------
  // Button sampling and edge detection (history advances only on ticks)
  // ---------------------------------------------------------------------------
  logic [3:0] btn_now;
  logic [3:0] dir_hist_q;
  logic       paint_hist_q;
  logic [3:0] dir_edge;
  logic       paint_edge;
  logic [3:0] move_req;

  always_comb begin
    btn_now                = '0;
    btn_now[DIR_BIT_RIGHT] = btn_right;
    btn_now[DIR_BIT_LEFT]  = btn_left;
    btn_now[DIR_BIT_DOWN]  = btn_down;
    btn_now[DIR_BIT_UP]    = btn_up;
  end

  assign dir_edge   = btn_now & ~dir_hist_q;
  assign paint_edge = btn_paint & ~paint_hist_q;

  // History keeps updating during a sweep so a button held across the end
  // of the sweep does not look like a fresh press afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_hist_q   <= '0;
      paint_hist_q <= 1'b0;
    end else if (tick) begin
      dir_hist_q   <= btn_now;
      paint_hist_q <= btn_paint;
    end
  end

`ifdef PX_AUTO_REPEAT_EN
  // Per-direction hold counter: set to 1 on the edge tick, saturates at
  // REPEAT_TICKS; once saturated every further held tick requests a move.
  localparam int unsigned   RW    = px_clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] R_MAX = RW'(REPEAT_TICKS);

  logic [3:0][RW-1:0] hold_q, hold_d;
  logic [3:0]         rpt_req;

  always_comb begin
    hold_d  = hold_q;
    rpt_req = '0;
    for (int i = 0; i < 4; i++) begin
      if (!btn_now[i]) begin
        hold_d[i] = '0;
      end else if (!dir_hist_q[i]) begin
        hold_d[i] = RW'(1);
      end else if (hold_q[i] == R_MAX) begin
        rpt_req[i] = 1'b1;
      end else begin
        hold_d[i] = hold_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      hold_q <= '0;
    else if (tick) hold_q <= hold_d;
  end

  assign move_req = dir_edge | rpt_req;
`else
  assign move_req = dir_edge;
`endif

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic [YW-1:0] y_inc, y_dec;
  dir_e          move_dir;

  assign y_inc    = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
  assign y_dec    = (y_q == '0) ? Y_MAX : y_q - 1'b1;
  assign move_dir = px_pick_dir(move_req);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (tick) begin
          if (clr) begin
            state_d = CLEAR;
            addr_d  = '0;
            data_d  = CLR_COLOR;
          end else if (paint_edge) begin
            state_d = PAINT;
            addr_d  = AW'(px_lin_addr(32'(x_q), 32'(y_q), COLS));
            data_d  = switch;
          end else begin
            case (move_dir)
              // Horizontal moves wrap into the adjacent row.
              DIR_RIGHT: begin
                if (x_q == X_MAX) begin
                  x_d = '0;
                  y_d = y_inc;
                end else begin
                  x_d = x_q + 1'b1;
                end
              end
              DIR_LEFT: begin
                if (x_q == '0) begin
                  x_d = X_MAX;
                  y_d = y_dec;
                end else begin
                  x_d = x_q - 1'b1;
                end
              end
              DIR_DOWN: y_d = y_inc;
              DIR_UP:   y_d = y_dec;
              default:  ;
            endcase
          end
        end
      end

      PAINT: state_d = IDLE;

      CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Write strobe is a pure state decode, so reset drops it immediately.
  assign px_wr       = (state_q != IDLE);
  assign busy        = (state_q == CLEAR);
  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign cur_x       = x_q;
  assign cur_y       = y_q;

endmodule

// File: tb/tb_px_cursor_painter.sv
module tb_px_cursor_painter;

  localparam int TD   = 4;
  localparam int NPIX = 192;

  localparam logic [4:0] B_R = 5'b00001;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_P = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_right = 1'b0, btn_left = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       btn_paint = 1'b0, clr = 1'b0;
  logic [2:0] sw = 3'b000;
  logic [7:0] mem_px_addr;
  logic [2:0] mem_px_data;
  logic       px_wr;
  logic [3:0] cur_x;
  logic [3:0] cur_y;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  px_cursor_painter #(
    .AW(8), .DW(3), .COLS(16), .ROWS(12), .TICK_DIV(TD),
    .CLR_COLOR(3'b111), .REPEAT_TICKS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_right(btn_right), .btn_left(btn_left), .btn_up(btn_up), .btn_down(btn_down),
    .btn_paint(btn_paint), .clr(clr), .switch(sw),
    .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .px_wr(px_wr),
    .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
  );

  // Write monitor: counts strobes and notes whether each followed a tick cycle.
  int         wr_count = 0;
  logic [7:0] last_addr = '0;
  logic [2:0] last_data = '0;
  bit         last_lat_ok = 1'b0;
  bit         prev_tick = 1'b0;

  always @(negedge clk) begin
    if (px_wr === 1'b1) begin
      wr_count    = wr_count + 1;
      last_addr   = mem_px_addr;
      last_data   = mem_px_data;
      last_lat_ok = prev_tick;
    end
    prev_tick = dut.tick;
  end

  // Hold a button set across exactly one tick, then release across one tick.
  task automatic press(input logic [4:0] b);
    @(negedge clk);
    {btn_paint, btn_up, btn_down, btn_left, btn_right} = b;
    repeat (TD) @(negedge clk);
    {btn_paint, btn_up, btn_down, btn_left, btn_right} = 5'b0;
    repeat (TD) @(negedge clk);
  endtask

  task automatic check_cursor(input string name, input int ex, input int ey);
    tests++;
    if (cur_x !== 4'(ex) || cur_y !== 4'(ey)) begin
      fails++;
      $display("FAIL %s: cursor got (%0d,%0d) want (%0d,%0d)", name, cur_x, cur_y, ex, ey);
    end
  endtask

  // Clear request held until the sweep starts; returns 1 if busy rose in time.
  task automatic start_clear(output bit found);
    found = 1'b0;
    clr = 1'b1;
    for (int k = 0; k < 2 * TD && !found; k++) begin
      @(negedge clk);
      if (busy === 1'b1) found = 1'b1;
    end
    clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (px_wr !== 1'b0) begin fails++; $display("FAIL rst_wr: got %b want 0", px_wr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (mem_px_addr !== 8'd0) begin fails++; $display("FAIL rst_addr: got %0d want 0", mem_px_addr); end
    tests++; if (mem_px_data !== 3'd0) begin fails++; $display("FAIL rst_data: got %0d want 0", mem_px_data); end
    check_cursor("rst_cursor", 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (px_wr !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL post_rst_idle: wr=%b busy=%b want 0/0", px_wr, busy);
    end
  endtask

  task automatic test_move();
    int base;
    base = wr_count;
    press(B_R);
    check_cursor("move_r1", 1, 0);
    press(B_R);
    press(B_R);
    press(B_D);
    check_cursor("move_r3_d1", 3, 1);
    tests++; if (wr_count !== base) begin fails++; $display("FAIL move_no_wr: got %0d writes want 0", wr_count - base); end
  endtask

  task automatic test_paint();
    int base;
    sw = 3'b010;
    base = wr_count;
    press(B_P);
    sw = 3'b000;
    tests++; if (wr_count - base !== 1) begin fails++; $display("FAIL paint_count: got %0d want 1", wr_count - base); end
    tests++; if (last_addr !== 8'd19) begin fails++; $display("FAIL paint_addr: got %0d want 19", last_addr); end
    tests++; if (last_data !== 3'b010) begin fails++; $display("FAIL paint_data: got %b want 010", last_data); end
    tests++; if (last_lat_ok !== 1'b1) begin fails++; $display("FAIL paint_latency: got %b want 1", last_lat_ok); end
    check_cursor("paint_cursor", 3, 1);
  endtask

  task automatic test_wrap();
    repeat (3) press(B_L);
    check_cursor("left_to_x0", 0, 1);
    press(B_L);
    check_cursor("left_wrap_row", 15, 0);
    press(B_U);
    check_cursor("up_wrap", 15, 11);
    press(B_R);
    check_cursor("right_wrap_corner", 0, 0);
    press(B_L);
    check_cursor("left_wrap_corner", 15, 11);
    press(B_D);
    check_cursor("down_wrap", 15, 0);
    press(B_U);
    check_cursor("up_wrap2", 15, 11);
  endtask

  task automatic test_priority();
    int base;
    sw = 3'b101;
    base = wr_count;
    press(B_P | B_R | B_L);
    tests++; if (wr_count - base !== 1 || last_addr !== 8'd191 || last_data !== 3'b101) begin
      fails++; $display("FAIL prio_paint: writes=%0d addr=%0d data=%b want 1/191/101", wr_count - base, last_addr, last_data);
    end
    check_cursor("prio_paint_nomove", 15, 11);
    press(B_R | B_L | B_D | B_U);
    check_cursor("prio_right", 0, 0);
    press(B_L | B_D | B_U);
    check_cursor("prio_left", 15, 11);
    press(B_D | B_U);
    check_cursor("prio_down", 15, 0);
    press(B_U);
    check_cursor("prio_up", 15, 11);
  endtask

  task automatic test_clear();
    bit found;
    int base, errs;
    base = wr_count;
    errs = 0;
    start_clear(found);
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL clr_start: busy got %b want 1", busy); end
    for (int i = 0; i < NPIX; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 20)  btn_right = 1'b1;
      if (i == 40)  btn_right = 1'b0;
      if (i == 60)  btn_paint = 1'b1;
      if (i == 100) btn_paint = 1'b0;
      if (i == 150) btn_left  = 1'b1;
      if (px_wr !== 1'b1 || busy !== 1'b1 || mem_px_addr !== i[7:0] || mem_px_data !== 3'b111) begin
        errs++;
        if (errs < 4) $display("FAIL clr_step: i=%0d wr=%b busy=%b addr=%0d data=%b want 1/1/%0d/111",
                               i, px_wr, busy, mem_px_addr, mem_px_data, i);
      end
    end
    tests++; if (errs !== 0) begin fails++; $display("FAIL clr_sweep: got %0d bad cycles want 0", errs); end
    @(negedge clk);
    tests++; if (busy !== 1'b0 || px_wr !== 1'b0) begin
      fails++; $display("FAIL clr_end: busy=%b wr=%b want 0/0", busy, px_wr);
    end
    check_cursor("clr_cursor", 0, 0);
    repeat (3 * TD) @(negedge clk);
    btn_left = 1'b0;
    repeat (2 * TD) @(negedge clk);
    check_cursor("clr_no_stale", 0, 0);
    tests++; if (wr_count - base !== NPIX) begin fails++; $display("FAIL clr_writes: got %0d want %0d", wr_count - base, NPIX); end
  endtask

  task automatic test_clr_held();
    int n1, gap;
    bit found;
    found = 1'b0;
    clr = 1'b1;
    for (int k = 0; k < 2 * TD && !found; k++) begin
      @(negedge clk);
      if (busy === 1'b1) found = 1'b1;
    end
    n1 = 0;
    do begin
      n1++;
      @(negedge clk);
    end while (busy === 1'b1 && n1 < 400);
    tests++; if (n1 !== NPIX) begin fails++; $display("FAIL held_len: got %0d busy clks want %0d", n1, NPIX); end
    gap = 0;
    while (busy !== 1'b1 && gap < 4 * TD) begin
      gap++;
      @(negedge clk);
    end
    clr = 1'b0;
    tests++; if (gap !== TD || mem_px_addr !== 8'd0) begin
      fails++; $display("FAIL held_retrigger: gap=%0d addr=%0d want %0d/0", gap, mem_px_addr, TD);
    end
    n1 = 0;
    while (busy === 1'b1 && n1 < 400) begin
      n1++;
      @(negedge clk);
    end
    repeat (2 * TD) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL held_release: busy got %b want 0", busy); end
  endtask

  task automatic test_rst_mid();
    bit found;
    int n, base;
    press(B_R);
    press(B_R);
    check_cursor("pre_abort", 2, 0);
    start_clear(found);
    n = 0;
    while (mem_px_addr !== 8'd50 && n < 300) begin
      n++;
      @(negedge clk);
    end
    tests++; if (found !== 1'b1 || mem_px_addr !== 8'd50) begin
      fails++; $display("FAIL abort_reach: found=%b addr=%0d want 1/50", found, mem_px_addr);
    end
    rst = 1'b0;
    #1;
    tests++; if (px_wr !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_now: wr=%b busy=%b want 0/0", px_wr, busy);
    end
    @(negedge clk);
    base = wr_count;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3 * TD) @(negedge clk);
    tests++; if (wr_count !== base || busy !== 1'b0 || px_wr !== 1'b0) begin
      fails++; $display("FAIL abort_after: writes=%0d busy=%b wr=%b want 0/0/0", wr_count - base, busy, px_wr);
    end
    check_cursor("abort_cursor", 0, 0);
  endtask

  task automatic test_repeat();
    int ex;
`ifdef PX_AUTO_REPEAT_EN
    ex = 7;
`else
    ex = 1;
`endif
    @(negedge clk);
    btn_right = 1'b1;
    repeat (10 * TD) @(negedge clk);
    btn_right = 1'b0;
    repeat (2 * TD) @(negedge clk);
    check_cursor("hold_right", ex, 0);
  endtask

  initial begin
    test_reset();
    test_move();
    test_paint();
    test_wrap();
    test_priority();
    test_clear();
    test_clr_held();
    test_rst_mid();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, %0d of %0d comparisons failed so far", fails, tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/px_cursor_painter.md
Name: px_cursor_painter

Overview:
- Parametrised successor of the single-button pixel painter for the VGA framebuffer.
- Keeps a 2-D cursor on a COLS x ROWS board, moved by four direction buttons.
- Paints the switch colour at the cursor, and clears the whole board with a one-pixel-per-clock sweep.
- Drives the framebuffer write port (addr/data/wr) that is read by the VGA scan-out.

Parameters:
- AW, 8: framebuffer address width; elaboration error if 2**AW < COLS*ROWS.
- DW, 3: pixel colour width.
- COLS, 16: board width in pixels.
- ROWS, 12: board height in pixels.
- TICK_DIV, 10714286: clk cycles per game tick (75 MHz / 7 Hz).
- CLR_COLOR, 3'b111: colour written by the clear sweep, DW bits.
- REPEAT_TICKS, 4: hold time in ticks before auto-repeat (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_right, btn_left, btn_up, btn_down  in  1 each  cursor move buttons, level, synchronous to clk.
- btn_paint  in  1  paint current pixel.
- clr  in  1  clear-board request, level.
- switch  in  DW  paint colour.
- mem_px_addr  out  AW  write address = cur_y*COLS + cur_x.
- mem_px_data  out  DW  write data.
- px_wr  out  1  write strobe, one clk wide per pixel.
- cur_x  out  clog2(COLS)  cursor column.
- cur_y  out  clog2(ROWS)  cursor row.
- busy  out  1  high during the clear sweep.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - cur_x=0, cur_y=0.
  - px_wr=0, mem_px_addr=0, mem_px_data=0, busy=0.
  - tick counter=0, all button history=0.
- Tick: a one-clk pulse every TICK_DIV clks. Buttons and clr are sampled only on the tick.
- A button event is a sampled rising edge: sampled now 1, previous tick sample 0. Each button is edge-detected independently.
- Event priority within one tick: clr > paint > move.
- Move order when several direction buttons have edges on the same tick: right, left, down, up. Only the highest-priority one applies.
- States:
  - IDLE:
    - On a tick with a clr level: go to CLEAR, sweep address=0, busy=1 from the next clk.
    - Else on a paint edge: go to PAINT.
    - Else on a move edge: update the cursor, stay in IDLE.
  - PAINT: exactly one clk.
    - px_wr=1, mem_px_addr=cur_y*COLS+cur_x, mem_px_data=switch as sampled on the tick.
    - Then IDLE.
  - CLEAR: one write per clk.
    - px_wr=1, mem_px_addr=sweep, mem_px_data=CLR_COLOR.
    - Sweep runs from 0 to COLS*ROWS-1.
    - After the last write: cur_x=cur_y=0, busy=0, state=IDLE.
- Latency:
  - Paint write occurs 1 clk after the tick.
  - Clear takes COLS*ROWS clks.
  - Cursor updates 1 clk after the tick.
- Wrap-around:
  - right at x=COLS-1: x=0, y=y+1 (y wraps ROWS-1 -> 0).
  - left at x=0: x=COLS-1, y=y-1 (y wraps 0 -> ROWS-1).
  - up/down wrap y only, x is unchanged.
- Buttons are ignored while busy. Their history still updates on each tick, so no stale edges fire after the sweep.
- clr held continuously re-triggers only after the sweep completes and on the next tick.
- px_wr=0 in IDLE. Addresses never exceed COLS*ROWS-1.
- Reset mid-sweep: abort immediately, px_wr=0, no further writes.

Optional Feature:
- Macro: PX_AUTO_REPEAT_EN.
- Defined: a direction button held for REPEAT_TICKS consecutive ticks after its edge generates one move per tick while held. Priority is unchanged. A release resets the hold counter.
- Undefined: edges only; holding a button moves the cursor exactly once.

Decomposition:
- Package px_paint_pkg holds:
  - state enum (IDLE, PAINT, CLEAR);
  - direction priority encoding;
  - function computing clog2;
  - function computing linear address from x, y, COLS.
- Sub-module px_tick_gen(TICK_DIV): free-running counter producing a one-clk tick pulse, async active-low reset.

Test Plan:
- Reset, then right edge x3 and down edge x1 (COLS=16) -> cur_x=3, cur_y=1, px_wr never asserted.
- At x=3,y=1 with switch=3'b010, paint edge -> exactly one px_wr pulse, addr=19, data=3'b010, 1 clk after the tick.
- At x=15,y=11, right edge -> x=0,y=0. Then left edge -> x=15,y=11.
- clr held for one tick (COLS*ROWS=192) -> busy high for 192 clks, addresses 0..191 each written once with 3'b111, then cursor at 0,0. Buttons pressed during the sweep have no effect.
- rst asserted at sweep address 50 -> px_wr low on the same edge. After release: IDLE, cursor 0,0, busy=0.
- With PX_AUTO_REPEAT_EN and REPEAT_TICKS=4, right held 10 ticks -> one move at the edge, then one per tick from tick 4 on, so x=7. Without the macro -> x=1.
